// File: rtl/simon_pkg.sv
// Shared definitions for the SIMON 64/96 host front end: widths, FSM states
// and the reference test vectors.
package simon_pkg;

  localparam int SIMON_N       = 32;
  localparam int SIMON_M       = 3;
  localparam int SIMON_BLOCK_W = 2 * SIMON_N;
  localparam int SIMON_KEY_W   = SIMON_M * SIMON_N;

  typedef enum logic [3:0] {
    S_IDLE  = 4'd0,
    S_KFILL = 4'd1,
    S_KREQ  = 4'd2,
    S_KWAIT = 4'd3,
    S_DFILL = 4'd4,
    S_DREQ  = 4'd5,
    S_RUN   = 4'd6,
    S_OUT0  = 4'd7,
    S_OUT1  = 4'd8
  } host_state_e;

  localparam logic [SIMON_KEY_W-1:0]   TV_KEY    = 96'h13121110_0b0a0908_03020100;
  localparam logic [SIMON_BLOCK_W-1:0] TV_PLAIN  = 64'h6f722067_6e696c63;
  localparam logic [SIMON_BLOCK_W-1:0] TV_CIPHER = 64'h5ca2e27f_111a8fc8;

endpackage

// File: rtl/simon_host_if_if.sv
// Host-side word streams of the SIMON front end: a valid/ready input stream
// carrying key/data words and a valid/ready output stream carrying results.
interface simon_host_if_if
  import simon_pkg::*;
#(
  parameter int N = SIMON_N
) ();

  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] in_word;
  logic         in_kind;
  logic         in_dec;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] out_word;

  modport master (
    output in_valid, in_word, in_kind, in_dec, out_ready,
    input  in_ready, out_valid, out_word
  );

  modport slave (
    input  in_valid, in_word, in_kind, in_dec, out_ready,
    output in_ready, out_valid, out_word
  );

endinterface

// File: rtl/simon_host_if.sv
// Word-serial host front end for the SIMON 64/96 core: assembles key and
// block, drives the core load handshakes and streams the result back.
module simon_host_if
  import simon_pkg::*;
#(
  parameter int N = SIMON_N,
  parameter int M = SIMON_M
) (
  input  logic           clk,
  input  logic           nR,
  simon_host_if_if.slave host,
  output logic [2*N-1:0] plain,
  output logic [M*N-1:0] key,
  output logic           newKey,
  output logic           newData,
  output logic           enc_dec,
  output logic           readData,
  input  logic           ldKey,
  input  logic           ldData,
  input  logic           doneKey,
  input  logic           doneData,
  input  logic [2*N-1:0] cipher
);

  localparam int            CW    = $clog2(M + 1);
  localparam logic [CW-1:0] KLAST = CW'(M - 1);

  host_state_e    state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           key_ok_q, key_ok_d;
  logic [M*N-1:0] key_q, key_d;
  logic [2*N-1:0] plain_q, plain_d;
  logic           enc_dec_q, enc_dec_d;
  logic           new_key_q, new_key_d;
  logic           new_data_q, new_data_d;
  logic           read_data_q, read_data_d;
  logic           out_valid_q, out_valid_d;
  logic [N-1:0]   out_word_q, out_word_d;
  logic [N-1:0]   cap_q, cap_d;
  logic           in_ready_s;
  logic           accept_s;

  // Word acceptance depends on the offered kind so a mismatched word stalls in place
  always_comb begin
    in_ready_s = 1'b0;
    if (!nR) begin
      in_ready_s = 1'b0;
    end else begin
      case (state_q)
        S_IDLE:  in_ready_s = host.in_kind | key_ok_q;
        S_KFILL: in_ready_s = host.in_kind;
        S_DFILL: in_ready_s = ~host.in_kind;
        default: in_ready_s = 1'b0;
      endcase
    end
  end

  assign accept_s = host.in_valid & in_ready_s;

  // Next-state and next-output logic for the single load/run/return FSM
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    key_ok_d    = key_ok_q;
    key_d       = key_q;
    plain_d     = plain_q;
    enc_dec_d   = enc_dec_q;
    new_key_d   = 1'b0;
    new_data_d  = 1'b0;
    read_data_d = 1'b0;
    out_valid_d = out_valid_q;
    out_word_d  = out_word_q;
    cap_d       = cap_q;

    case (state_q)
      S_IDLE: begin
        if (accept_s && host.in_kind) begin
          key_d[N-1:0] = host.in_word;
          key_ok_d     = 1'b0;
          if (KLAST == {CW{1'b0}}) begin
            state_d   = S_KREQ;
            new_key_d = 1'b1;
          end else begin
            cnt_d   = CW'(1);
            state_d = S_KFILL;
          end
        end else if (accept_s) begin
          plain_d[2*N-1:N] = host.in_word;
          enc_dec_d        = host.in_dec;
          state_d          = S_DFILL;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_KFILL: begin
        if (accept_s) begin
          key_d[int'(cnt_q)*N +: N] = host.in_word;
          if (cnt_q == KLAST) begin
            cnt_d     = {CW{1'b0}};
            state_d   = S_KREQ;
            new_key_d = 1'b1;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end else begin
          cnt_d = cnt_q;
        end
      end
      S_KREQ: begin
        if (ldKey) begin
          state_d = S_KWAIT;
        end else begin
          new_key_d = 1'b1;
        end
      end
      S_KWAIT: begin
        if (doneKey) begin
          key_ok_d = 1'b1;
          state_d  = S_IDLE;
        end else begin
          state_d = S_KWAIT;
        end
      end
      S_DFILL: begin
        if (accept_s) begin
          plain_d[N-1:0] = host.in_word;
          state_d        = S_DREQ;
          new_data_d     = 1'b1;
        end else begin
          state_d = S_DFILL;
        end
      end
      S_DREQ: begin
        if (ldData) begin
          state_d = S_RUN;
        end else begin
          new_data_d = 1'b1;
        end
      end
      S_RUN: begin
        // The low half is parked so the core may drop cipher once released
        if (doneData) begin
          out_word_d  = cipher[2*N-1:N];
          cap_d       = cipher[N-1:0];
          out_valid_d = 1'b1;
          read_data_d = 1'b1;
          state_d     = S_OUT0;
        end else begin
          state_d = S_RUN;
        end
      end
      S_OUT0: begin
        if (host.out_ready) begin
          out_word_d = cap_q;
          state_d    = S_OUT1;
        end else begin
          state_d = S_OUT0;
        end
      end
      S_OUT1: begin
        if (host.out_ready) begin
          out_valid_d = 1'b0;
          state_d     = S_IDLE;
        end else begin
          state_d = S_OUT1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and registered outputs, synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!nR) begin
      state_q     <= S_IDLE;
      cnt_q       <= {CW{1'b0}};
      key_ok_q    <= 1'b0;
      key_q       <= {(M*N){1'b0}};
      plain_q     <= {(2*N){1'b0}};
      enc_dec_q   <= 1'b0;
      new_key_q   <= 1'b0;
      new_data_q  <= 1'b0;
      read_data_q <= 1'b0;
      out_valid_q <= 1'b0;
      out_word_q  <= {N{1'b0}};
      cap_q       <= {N{1'b0}};
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      key_ok_q    <= key_ok_d;
      key_q       <= key_d;
      plain_q     <= plain_d;
      enc_dec_q   <= enc_dec_d;
      new_key_q   <= new_key_d;
      new_data_q  <= new_data_d;
      read_data_q <= read_data_d;
      out_valid_q <= out_valid_d;
      out_word_q  <= out_word_d;
      cap_q       <= cap_d;
    end
  end

  assign host.in_ready  = in_ready_s;
  assign host.out_valid = out_valid_q;
  assign host.out_word  = out_word_q;
  assign plain          = plain_q;
  assign key            = key_q;
  assign newKey         = new_key_q;
  assign newData        = new_data_q;
  assign enc_dec        = enc_dec_q;
  assign readData       = read_data_q;

endmodule

// File: tb/tb_simon_host_if.sv
// Bench for simon_host_if: the bench plays host and core, and a transaction
// model checks every DUT output on every falling clock edge.
module tb_simon_host_if;

  localparam int N = 32;
  localparam int M = 3;

  logic        clk;
  logic        nR;
  logic [63:0] plain;
  logic [95:0] key;
  logic        newKey, newData, enc_dec, readData;
  logic        ldKey, ldData, doneKey, doneData;
  logic [63:0] cipher;

  simon_host_if_if #(.N(N)) hb ();

  simon_host_if #(.N(N), .M(M)) dut (
    .clk(clk), .nR(nR), .host(hb.slave),
    .plain(plain), .key(key), .newKey(newKey), .newData(newData),
    .enc_dec(enc_dec), .readData(readData), .ldKey(ldKey), .ldData(ldData),
    .doneKey(doneKey), .doneData(doneData), .cipher(cipher)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_bad  = 0;
  int rd_cnt = 0;

  task automatic chk(input string nm, input logic [95:0] act, input logic [95:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h", nm, act, exp);
    end
  endtask

  // ---------------- transaction-level model ----------------
  logic [95:0] m_key;
  logic [63:0] m_plain;
  logic        m_enc, m_key_ok, m_kreq, m_kwait, m_dreq, m_run, m_rd;
  int          m_kcnt, m_dcnt;
  logic [31:0] m_outq[$];
  logic [31:0] m_last_out;

  function automatic logic exp_ready(input logic rst_n, input logic kind);
    if (!rst_n) return 1'b0;
    if (m_kreq || m_kwait || m_dreq || m_run || m_outq.size() != 0) return 1'b0;
    if (m_kcnt != 0) return kind;
    if (m_dcnt != 0) return !kind;
    return kind || m_key_ok;
  endfunction

  task automatic model_reset();
    m_key = '0; m_plain = '0; m_enc = 1'b0; m_key_ok = 1'b0;
    m_kreq = 1'b0; m_kwait = 1'b0; m_dreq = 1'b0; m_run = 1'b0; m_rd = 1'b0;
    m_kcnt = 0; m_dcnt = 0; m_outq.delete(); m_last_out = '0;
  endtask

  task automatic model_step();
    logic acc, kr, kw, dr, rn;
    acc = hb.in_valid && exp_ready(1'b1, hb.in_kind);
    kr = m_kreq; kw = m_kwait; dr = m_dreq; rn = m_run;
    m_rd = 1'b0;
    if (m_outq.size() != 0 && hb.out_ready) void'(m_outq.pop_front());
    if (kw && doneKey) begin m_kwait = 1'b0; m_key_ok = 1'b1; end
    if (kr && ldKey)   begin m_kreq = 1'b0; m_kwait = 1'b1; end
    if (dr && ldData)  begin m_dreq = 1'b0; m_run = 1'b1; end
    if (rn && doneData) begin
      m_run = 1'b0;
      m_outq.push_back(cipher[63:32]);
      m_outq.push_back(cipher[31:0]);
      m_rd = 1'b1;
    end
    if (acc) begin
      if (hb.in_kind) begin
        if (m_kcnt == 0) m_key_ok = 1'b0;
        m_key[m_kcnt*N +: N] = hb.in_word;
        m_kcnt++;
        if (m_kcnt == M) begin m_kcnt = 0; m_kreq = 1'b1; end
      end else if (m_dcnt == 0) begin
        m_plain[63:32] = hb.in_word; m_enc = hb.in_dec; m_dcnt = 1;
      end else begin
        m_plain[31:0] = hb.in_word; m_dcnt = 0; m_dreq = 1'b1;
      end
    end
    if (m_outq.size() != 0) m_last_out = m_outq[0];
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk);
      if (!nR) model_reset();
      else     model_step();
    end
  end

  // Per-cycle comparison against the model
  initial begin
    @(posedge clk);
    forever begin
      @(negedge clk);
      chk("in_ready",  hb.in_ready,  exp_ready(nR, hb.in_kind));
      chk("out_valid", hb.out_valid, m_outq.size() != 0);
      chk("out_word",  hb.out_word,  m_last_out);
      chk("newKey",    newKey,       m_kreq);
      chk("newData",   newData,      m_dreq);
      chk("readData",  readData,     m_rd);
      chk("enc_dec",   enc_dec,      m_enc);
      chk("key",       key,          m_key);
      chk("plain",     plain,        m_plain);
      if (readData === 1'b1) rd_cnt++;
    end
  end

  // ---------------- core stand-in ----------------
  function automatic logic [63:0] core_fn(input logic [63:0] p, input logic d, input logic [95:0] k);
    if (!d && p == 64'h6f7220676e696c63) return 64'h5ca2e27f111a8fc8;
    if (d && p == 64'h5ca2e27f111a8fc8)  return 64'h6f7220676e696c63;
    return {p[31:0] ^ k[31:0], p[63:32] + k[95:64]};
  endfunction

  initial begin
    logic [63:0] res;
    int kdly, ddly;
    bit kpend, dpend;
    ldKey = 1'b0; ldData = 1'b0; doneKey = 1'b0; doneData = 1'b0; cipher = '0;
    res = '0; kdly = 0; ddly = 0; kpend = 1'b0; dpend = 1'b0;
    forever begin
      @(negedge clk);
      if (!nR) begin
        ldKey = 1'b0; ldData = 1'b0; doneKey = 1'b0; doneData = 1'b0;
        kpend = 1'b0; dpend = 1'b0;
      end else begin
        if (newKey) begin
          doneKey = 1'b0;
          ldKey = ($urandom_range(0, 2) == 0);
          if (ldKey) begin kpend = 1'b1; kdly = $urandom_range(0, 3); end
        end else begin
          ldKey = ($urandom_range(0, 7) == 0);
          if (kpend) begin
            if (kdly == 0) begin doneKey = 1'b1; kpend = 1'b0; end
            else kdly--;
          end
        end
        if (newData) begin
          doneData = 1'b0;
          cipher = {$urandom, $urandom};
          ldData = ($urandom_range(0, 2) == 0);
          if (ldData) begin dpend = 1'b1; ddly = $urandom_range(0, 4); res = core_fn(plain, enc_dec, key); end
        end else begin
          ldData = ($urandom_range(0, 7) == 0);
          if (dpend) begin
            if (ddly == 0) begin doneData = 1'b1; cipher = res; dpend = 1'b0; end
            else begin ddly--; cipher = {$urandom, $urandom}; end
          end
        end
      end
    end
  end

  // ---------------- host driver ----------------
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    hb.in_valid = 1'b0;
    repeat (n) begin
      hb.in_kind = 1'($urandom_range(0, 1));
      hb.in_word = $urandom;
      tick();
    end
  endtask

  task automatic send(input logic kind, input logic dec, input logic [31:0] w);
    bit got = 1'b0;
    hb.in_valid = 1'b1; hb.in_kind = kind; hb.in_dec = dec; hb.in_word = w;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (hb.in_ready === 1'b1) got = 1'b1;
      tick();
      if (got) break;
    end
    chk("send_accept", got, 1'b1);
    hb.in_valid = 1'b0;
  endtask

  task automatic recv(output logic [31:0] w, input bit rnd);
    bit got = 1'b0;
    w = '0;
    for (int i = 0; i < 300; i++) begin
      hb.out_ready = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
      @(negedge clk);
      if (hb.out_valid === 1'b1 && hb.out_ready) begin w = hb.out_word; got = 1'b1; end
      tick();
      if (got) break;
    end
    chk("recv_handshake", got, 1'b1);
    hb.out_ready = 1'b0;
  endtask

  task automatic load_key(input logic [95:0] k);
    send(1'b1, 1'($urandom_range(0, 1)), k[31:0]);
    send(1'b1, 1'($urandom_range(0, 1)), k[63:32]);
    send(1'b1, 1'($urandom_range(0, 1)), k[95:64]);
  endtask

  task automatic run_block(input logic [63:0] d, input logic dec, input bit rnd,
                           output logic [31:0] r0, output logic [31:0] r1);
    send(1'b0, dec, d[63:32]);
    send(1'b0, 1'($urandom_range(0, 1)), d[31:0]);
    recv(r0, rnd);
    recv(r1, rnd);
  endtask

  task automatic offer_data_stalled(input string nm, input int n);
    hb.in_valid = 1'b1; hb.in_kind = 1'b0; hb.in_word = 32'hdead_beef;
    repeat (n) begin
      @(negedge clk);
      chk(nm, hb.in_ready, 1'b0);
      tick();
    end
    hb.in_valid = 1'b0;
  endtask

  initial begin
    logic [31:0] r0, r1;
    bit got;
    nR = 1'b0;
    hb.in_valid = 1'b0; hb.in_kind = 1'b1; hb.in_dec = 1'b0; hb.in_word = '0; hb.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    chk("rst_in_ready", hb.in_ready, 1'b0);
    chk("rst_key", key, 96'h0);
    chk("rst_plain", plain, 64'h0);
    chk("rst_out_word", hb.out_word, 32'h0);
    chk("rst_ctrl", {hb.out_valid, newKey, newData, readData, enc_dec}, 5'b0);
    tick();
    nR = 1'b1;
    @(negedge clk);
    chk("idle_key_ready", hb.in_ready, 1'b1);
    tick();

    // data before any key stalls
    offer_data_stalled("nokey_data_stall", 6);

    // key load, with a data word offered during the fill
    send(1'b1, 1'b0, 32'h03020100);
    offer_data_stalled("kfill_data_stall", 4);
    send(1'b1, 1'b0, 32'h0b0a0908);
    send(1'b1, 1'b0, 32'h13121110);
    @(negedge clk);
    chk("newkey_after_fill", newKey, 1'b1);
    tick();
    hb.in_kind = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (hb.in_ready === 1'b1) got = 1'b1;
      tick();
      if (got) break;
    end
    chk("key_ok_data_ready", got, 1'b1);
    chk("key_value", key, 96'h13121110_0b0a0908_03020100);

    // encrypt vector with output back-pressure
    rd_cnt = 0;
    send(1'b0, 1'b0, 32'h6f722067);
    send(1'b0, 1'b1, 32'h6e696c63);
    chk("enc_plain", plain, 64'h6f7220676e696c63);
    got = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (hb.out_valid === 1'b1) got = 1'b1;
      tick();
      if (got) break;
    end
    chk("enc_out_valid", got, 1'b1);
    for (int i = 0; i < 5; i++) begin
      hb.in_kind = 1'(i & 1);
      @(negedge clk);
      chk("bp_out_word", hb.out_word, 32'h5ca2e27f);
      chk("bp_out_valid", hb.out_valid, 1'b1);
      chk("bp_in_ready", hb.in_ready, 1'b0);
      tick();
    end
    recv(r0, 1'b0);
    recv(r1, 1'b0);
    chk("enc_word0", r0, 32'h5ca2e27f);
    chk("enc_word1", r1, 32'h111a8fc8);
    chk("enc_readdata_pulses", rd_cnt, 1);

    // decrypt round trip
    send(1'b0, 1'b1, 32'h5ca2e27f);
    @(negedge clk);
    chk("dec_enc_dec", enc_dec, 1'b1);
    tick();
    send(1'b0, 1'b0, 32'h111a8fc8);
    recv(r0, 1'b1);
    recv(r1, 1'b1);
    chk("dec_word0", r0, 32'h6f722067);
    chk("dec_word1", r1, 32'h6e696c63);

    // randomized blocks and key reloads
    for (int it = 0; it < 30; it++) begin
      if ($urandom_range(0, 4) == 0) load_key({$urandom, $urandom, $urandom});
      else run_block({$urandom, $urandom}, 1'($urandom_range(0, 1)), 1'b1, r0, r1);
      idle($urandom_range(0, 2));
    end

    // reset while the core is being asked for the block
    send(1'b0, 1'b1, $urandom);
    send(1'b0, 1'b0, $urandom);
    nR = 1'b0;
    tick();
    @(negedge clk);
    chk("dreq_rst_key", key, 96'h0);
    chk("dreq_rst_plain", plain, 64'h0);
    chk("dreq_rst_ctrl", {hb.out_valid, newKey, newData, readData, enc_dec, hb.in_ready}, 6'b0);
    tick();
    nR = 1'b1;
    offer_data_stalled("dreq_rst_data_stall", 5);
    load_key(96'h13121110_0b0a0908_03020100);
    run_block(64'h6f7220676e696c63, 1'b0, 1'b1, r0, r1);
    chk("post_rst_word0", r0, 32'h5ca2e27f);
    chk("post_rst_word1", r1, 32'h111a8fc8);

    // reset with a partially filled key
    send(1'b1, 1'b0, 32'haaaa0001);
    send(1'b1, 1'b0, 32'haaaa0002);
    nR = 1'b0;
    tick();
    @(negedge clk);
    chk("kfill_rst_key", key, 96'h0);
    chk("kfill_rst_ctrl", {newKey, hb.in_ready}, 2'b0);
    tick();
    nR = 1'b1;
    offer_data_stalled("kfill_rst_data_stall", 4);
    load_key({$urandom, $urandom, $urandom});
    run_block({$urandom, $urandom}, 1'b1, 1'b1, r0, r1);
    idle(3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/simon_host_if.md
# simon_host_if

Word-serial host front end for the SIMON 64/96 core; sits directly upstream of it. It takes 32-bit key and data words from a valid/ready input stream and assembles the 96-bit key and 64-bit block. It drives the core's load handshakes, waits for the core to finish, and returns the 64-bit result as two words on a valid/ready output stream. One block is in flight at a time.

## Interface
Parameters:
- N, 32, word width; also half the block width.
- M, 3, key words per key.

Ports:
- clk  in  1  system clock.
- nR  in  1  synchronous active-low reset, sampled on rising clk.
- in_valid  in  1  host word valid.
- in_ready  out  1  word accepted when in_valid && in_ready.
- in_word  in  N  host word.
- in_kind  in  1  0 = data word, 1 = key word.
- in_dec  in  1  direction for the block; sampled with the first data word (1 = decrypt).
- out_valid  out  1  result word valid.
- out_ready  in  1  host accepts result word.
- out_word  out  N  result word.
- plain  out  2N  block to core.
- key  out  M×N  key to core.
- newKey, newData  out  1  load requests to core.
- enc_dec  out  1  direction to core.
- readData  out  1  one-cycle result release to core.
- ldKey, ldData  in  1  one-cycle load acknowledges from core.
- doneKey, doneData  in  1  level "key expanded" / "result valid" from core.
- cipher  in  2N  result from core.

## Operation
FSM states and transitions:
- IDLE → KFILL on an accepted key word.
- IDLE → DFILL on an accepted data word, only if key_ok.
- KFILL → KREQ after M key words.
- KREQ: newKey=1; → KWAIT when ldKey=1.
- KWAIT → IDLE when doneKey=1; sets key_ok.
- DFILL → DREQ after 2 data words.
- DREQ: newData=1; → RUN when ldData=1.
- RUN → OUT0 when doneData=1; captures cipher, pulses readData.
- OUT0 → OUT1 on an out handshake.
- OUT1 → IDLE on an out handshake.

Word placement:
- Key words fill key[0], key[1], key[2] in arrival order.
- The first data word goes to plain[2N-1:N], the second to plain[N-1:0].
- OUT0 sends the captured cipher[2N-1:N]; OUT1 sends cipher[N-1:0].

in_ready:
- IDLE: 1 for key words; 1 for data words only if key_ok.
- KFILL: 1 for key words only.
- DFILL: 1 for data words only.
- All other states: 0. A word of the other kind stalls; it is never dropped.

Other rules:
- key_ok clears when a key word is accepted in IDLE. A key reload therefore blocks data until the new doneKey.
- enc_dec is registered from in_dec on the first data word and held until the next block's first data word.
- plain and key hold their last loaded value; they are never cleared except by reset.

## Timing
Reset values (nR=0, synchronous):
- State IDLE, key_ok=0, fill counters 0.
- in_ready=0 during the reset cycle.
- out_valid, newKey, newData, readData, enc_dec = 0.
- plain, key, out_word = 0.

Cycle-level behaviour:
- newKey rises the cycle after the M-th key word is accepted. It is held high through the cycle in which ldKey=1 is sampled, then drops the next cycle. newData follows the same rule with ldData.
- doneData=1 in RUN: readData=1 for exactly that cycle+1 (registered). out_valid=1 from the same cycle.
- Output is zero-bubble: two words in two cycles if out_ready=1 is held.
- Minimum turnaround: the first in_ready of the next block comes one cycle after the OUT1 handshake.
- ldKey/ldData seen outside KREQ/DREQ are ignored. So is doneData outside RUN.
- doneKey in KWAIT is accepted even on the same cycle ldKey drops.
- nR=0 mid-operation aborts immediately to reset values. A partially filled key is lost; the host must reload the full key.
- in_valid may drop between words; fill counters hold.

## Structure
Shared package simon_pkg holds:
- The state enum.
- Word/block width constants derived from N and M.
- Named test-vector constants.

No sub-module: the block is a single FSM with a fill counter and a capture register. The top-level wrapper instantiates this block and the core, connecting ports by name.

## Test plan
- **Key load:** reset, then key words 03020100, 0b0a0908, 13121110 → key = {13121110, 0b0a0908, 03020100}. newKey held until ldKey, then IDLE with key_ok=1.
- **Encrypt vector:** data 6f722067, 6e696c63 with in_dec=0 → plain = 6f7220676e696c63. The core returns 5ca2e27f111a8fc8; out words are 5ca2e27f then 111a8fc8, with a one-cycle readData.
- **Decrypt round-trip:** data 5ca2e27f, 111a8fc8 with in_dec=1 → enc_dec=1; out words are 6f722067 then 6e696c63.
- **Ordering:** a data word offered before any key, or during KFILL → in_ready=0, word retained. Then load the key and the word is accepted.
- **Back-pressure:** out_ready=0 for 5 cycles in OUT0 → out_word stable at 5ca2e27f, no state change, in_ready=0.
- **Reset mid-operation:** nR=0 in DREQ, and separately after 2 of 3 key words → all outputs at reset values next cycle. A later data word is stalled until a fresh key completes.
